// File: rtl/query_tx_if.sv
// query_tx_if
//   Bundles the Query transmitter's request, field and serial-bit signals.
//
//   Request side (driven by the reader control FSM):
//     start                          one-cycle request to send a Query
//     dr, m, trext, sel, session,
//     target, q                      Query field values, sampled on the start edge
//   Serial side:
//     out_dat / out_vld              current bit and its valid flag (from query_tx)
//     out_rdy                        downstream accepts the bit (from the modulator)
//   Status (from query_tx):
//     busy, done, dbg_state
//
//   Handshake: a bit moves on every rising clock edge where out_vld and
//   out_rdy are both 1. Once out_vld is raised, out_dat stays stable and
//   out_vld stays high until that bit has moved. out_rdy may be raised or
//   lowered in any cycle and does not depend on out_vld.
//
//   Modports: master is the controller/modulator side, slave is query_tx.
interface query_tx_if;
  logic       start;
  logic       dr;
  logic [1:0] m;
  logic       trext;
  logic [1:0] sel;
  logic [1:0] session;
  logic       target;
  logic [3:0] q;
  logic       out_dat;
  logic       out_vld;
  logic       out_rdy;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  modport master (
    output start, dr, m, trext, sel, session, target, q, out_rdy,
    input  out_dat, out_vld, busy, done, dbg_state
  );

  modport slave (
    input  start, dr, m, trext, sel, session, target, q, out_rdy,
    output out_dat, out_vld, busy, done, dbg_state
  );
endinterface

// File: rtl/query_tx.sv
// query_tx
//   Builds the EPC Gen2 Query command and emits it MSB-first as a 22-bit
//   serial frame: 4-bit command code, 13 field bits, then CRC-5 over the
//   first 17 bits (x^5+x^3+1, preset PRESET).
//
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   query_tx_if.slave: start + Query fields in, serial
//           out_dat/out_vld with out_rdy back-pressure, busy/done status,
//           dbg_state (current FSM state: 0 IDLE, 1 DATA, 2 CRC)
//
//   Timing: the first bit is valid the cycle after start is accepted; with
//   out_rdy held high a frame takes 22 cycles and done pulses in the cycle
//   after the last bit moves. start is ignored while a frame is in progress.
module query_tx #(
  parameter logic [4:0] PRESET = 5'b01001,
  parameter logic [3:0] CMD    = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  query_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_e;

  state_e      state_q,   state_d;
  logic [16:0] sh_q,      sh_d;
  logic [4:0]  crc_q,     crc_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic        out_dat_q, out_dat_d;
  logic        out_vld_q, out_vld_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  logic        xfer;
  logic        inv;
  logic [4:0]  crc_upd;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    xfer    = out_vld_q & bus.out_rdy;
    // sh_q[16] is the bit currently on out_dat while in DATA.
    inv     = sh_q[16] ^ crc_q[4];
    crc_upd = {crc_q[3], crc_q[2] ^ inv, crc_q[1], crc_q[0], inv};

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start && !busy_q) begin
          sh_d      = {CMD, bus.dr, bus.m, bus.trext, bus.sel, bus.session,
                       bus.target, bus.q};
          crc_d     = PRESET;
          state_d   = DATA;
          out_vld_d = 1'b1;
          busy_d    = 1'b1;
          out_dat_d = CMD[3];
        end
      end

      DATA: begin
        if (xfer) begin
          crc_d = crc_upd;
          sh_d  = {sh_q[15:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd16) begin
            // The first CRC bit already includes the 17th data bit.
            state_d   = CRC;
            out_dat_d = crc_upd[4];
          end else begin
            out_dat_d = sh_q[15];
          end
        end
      end

      CRC: begin
        if (xfer) begin
          // Plain left shift: the remainder is sent as-is, no feedback.
          crc_d     = {crc_q[3:0], 1'b0};
          cnt_d     = cnt_q + 5'd1;
          out_dat_d = crc_q[3];
          if (cnt_q == 5'd21) begin
            state_d   = IDLE;
            out_vld_d = 1'b0;
            out_dat_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cnt_d     = '0;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        out_vld_d = 1'b0;
        out_dat_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      crc_q     <= PRESET;
      cnt_q     <= '0;
      out_dat_q <= 1'b0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.out_dat   = out_dat_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_query_tx.sv
// tb_query_tx
//   Directed bench for query_tx: drives Query requests through
//   query_tx_if, collects the serial bits on a negedge monitor and compares
//   each finished frame against a CRC-5 reference frame held in exp_q.
module tb_query_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  query_tx_if bus ();

  query_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- counters / scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [21:0] exp_q[$];
  logic [21:0] rx_bits    = '0;
  int          rx_n       = 0;
  logic [21:0] last_frame = '0;
  int          done_cnt   = 0;
  logic        prev_stall = 1'b0;
  logic        prev_dat   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
    logic inv;
    inv = d ^ c[4];
    return {c[3], c[2] ^ inv, c[1], c[0], inv};
  endfunction

  function automatic logic [21:0] build_frame(input logic [12:0] f);
    logic [16:0] data;
    logic [4:0]  c;
    data = {4'b1000, f};
    c    = 5'b01001;
    for (int i = 16; i >= 0; i--) c = crc5_step(c, data[i]);
    return {data, c};
  endfunction

  function automatic logic [4:0] residue(input logic [21:0] fr);
    logic [4:0] c;
    c = 5'b01001;
    for (int i = 21; i >= 0; i--) c = crc5_step(c, fr[i]);
    return c;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (prev_stall && bus.out_vld)
      check("stall_hold", 32'(bus.out_dat), 32'(prev_dat));
    prev_stall = bus.out_vld && !bus.out_rdy;
    prev_dat   = bus.out_dat;
    if (bus.out_vld && bus.out_rdy) begin
      rx_bits = {rx_bits[20:0], bus.out_dat};
      rx_n++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      last_frame = rx_bits;
      check("rx_len", 32'(rx_n), 32'd22);
      check("residue", 32'(residue(rx_bits)), 32'd0);
      check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("frame", 32'(rx_bits), 32'(exp_q.pop_front()));
      rx_n = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [12:0] f);
    {bus.dr, bus.m, bus.trext, bus.sel, bus.session, bus.target, bus.q} = f;
  endtask

  task automatic run_frame(input logic [12:0] f, input bit rand_rdy);
    int target;
    int cyc;
    exp_q.push_back(build_frame(f));
    target = done_cnt + 1;
    set_fields(f);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_fields(13'($urandom));
    cyc = 0;
    while (done_cnt < target && cyc < 1000) begin
      bus.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    check("frame_timeout", 32'(done_cnt), 32'(target));
    bus.out_rdy = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    int          d0;
    logic [12:0] f;
    logic [21:0] ref_frame;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.out_rdy = 1'b1;
    set_fields('0);
    tick();
    tick();
    check("rst_vld",   32'(bus.out_vld),   32'd0);
    check("rst_dat",   32'(bus.out_dat),   32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: all fields zero, out_rdy=1
    exp_q.push_back(build_frame('0));
    bus.start = 1'b1;
    check("t1_vld_before", 32'(bus.out_vld), 32'd0);
    tick();
    bus.start = 1'b0;
    check("t1_first_bit", 32'(bus.out_dat), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    n = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 16) check("t1_state_data", 32'(bus.dbg_state), 32'd1);
      if (i == 17) check("t1_state_crc",  32'(bus.dbg_state), 32'd2);
      if (bus.out_vld) n++;
      tick();
    end
    check("t1_vld_cycles", 32'(n), 32'd22);
    check("t1_vld_low", 32'(bus.out_vld), 32'd0);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy_low", 32'(bus.busy), 32'd0);
    tick();
    check("t1_done_once", 32'(bus.done), 32'd0);
    check("t1_stream", 32'(last_frame), 32'(22'b1000_0000000000000_10000));
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Test 2: 200 random frames, out_rdy=1
    for (int k = 0; k < 200; k++) run_frame(13'($urandom), 1'b0);

    // Test 3: same fields with out_rdy=1 then out_rdy random
    for (int k = 0; k < 10; k++) begin
      f = 13'($urandom);
      run_frame(f, 1'b0);
      ref_frame = last_frame;
      run_frame(f, 1'b1);
      check("t3_same_stream", 32'(last_frame), 32'(ref_frame));
    end

    // Test 4: start re-pulsed at bits 3 and 20
    d0 = done_cnt;
    f  = 13'h1a5c;
    exp_q.push_back(build_frame(f));
    set_fields(f);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      bus.start = (i == 3 || i == 20);
      if (bus.start) set_fields(~f);
      tick();
    end
    bus.start = 1'b0;
    check("t4_done", 32'(bus.done), 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_vld) n++;
    end
    check("t4_no_second_vld", 32'(n), 32'd0);
    check("t4_one_frame", 32'(done_cnt), 32'(d0 + 1));

    // Test 5: reset after bit 10 with out_rdy=0
    d0 = done_cnt;
    set_fields(13'h0f0f);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.out_rdy = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_vld", 32'(bus.out_vld), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_state", 32'(bus.dbg_state), 32'd0);
    rst         = 1'b0;
    bus.out_rdy = 1'b1;
    rx_n        = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_vld) n++;
      tick();
    end
    check("t5_no_bits", 32'(n), 32'd0);
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    run_frame(13'h0f0f, 1'b0);
    check("t5_recover", 32'(done_cnt), 32'(d0 + 1));

    // Test 6: start held high, three frames with a single idle cycle between
    tick();
    d0 = done_cnt;
    f  = 13'h0c33;
    for (int k = 0; k < 3; k++) exp_q.push_back(build_frame(f));
    set_fields(f);
    bus.start = 1'b1;
    tick();
    for (int i = 0; i <= 68; i++) begin
      check("t6_vld_pattern", 32'(bus.out_vld), 32'((i % 23) != 22));
      if (i == 68) bus.start = 1'b0;
      tick();
    end
    tick();
    check("t6_frames", 32'(done_cnt), 32'(d0 + 3));
    check("t6_idle", 32'(bus.out_vld), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
